// File: rtl/angle_sweep_ctrl.sv
// Beam-steering angle sweep sequencer: steps wb_angle across [ANG_MIN, ANG_MAX], keeps the peak power.
// Optional WAIT watchdog enabled by defining SWEEP_TIMEOUT_EN.
module angle_sweep_ctrl #(
    parameter int ANG_MIN  = -90,
    parameter int ANG_MAX  = 90,
    parameter int ANG_STEP = 5,
    parameter int PWR_W    = 32,
    parameter int SETTLE   = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    continuous,
    output logic signed [7:0]       wb_angle,
    output logic                    wb_start,
    input  logic                    wb_done,
    input  logic [PWR_W-1:0]        wb_power,
    output logic signed [7:0]       best_angle,
    output logic [PWR_W-1:0]        best_power,
    output logic                    sweep_done,
    output logic                    busy,
    output logic                    timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ISSUE,
        S_WAIT,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic signed [7:0] MIN8        = 8'(ANG_MIN);
    localparam logic signed [8:0] MAX9        = 9'(ANG_MAX);
    localparam logic signed [8:0] STEP9       = 9'(ANG_STEP);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [7:0]       cur_q;
    logic signed [7:0]       run_ang_q;
    logic [PWR_W-1:0]        run_max_q;
    logic [PWR_W-1:0]        cap_q;
    logic signed [8:0]       nxt;
    logic                    win;
    logic                    begin_sweep;
    logic                    capture;
`ifdef SWEEP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    logic                    expire;
    logic                    terr_q;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        begin_sweep = 1'b0;
        capture     = 1'b0;
`ifdef SWEEP_TIMEOUT_EN
        expire      = 1'b0;
`endif
        // 9-bit add so cur=127 plus a step cannot wrap back into range.
        nxt = cur_q + STEP9;
        win = cap_q > run_max_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    begin_sweep = 1'b1;
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (wb_done) begin
                    capture = 1'b1;
                    state_d = S_COMPARE;
                end
`ifdef SWEEP_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    expire  = 1'b1;
                    state_d = S_COMPARE;
                end
`endif
            end
            S_COMPARE: state_d = (nxt > MAX9) ? S_DONE : S_SETTLE;
            S_DONE: begin
                if (continuous) begin
                    begin_sweep = 1'b1;
                    state_d     = S_SETTLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            cur_q      <= '0;
            run_ang_q  <= '0;
            run_max_q  <= '0;
            cap_q      <= '0;
            best_angle <= '0;
            best_power <= '0;
        end else begin
            cnt_q <= (state_d == state_q) ? cnt_q + 1'b1 : '0;
            if (begin_sweep) begin
                cur_q     <= MIN8;
                run_ang_q <= MIN8;
                run_max_q <= '0;
            end
            if (capture) cap_q <= wb_power;
`ifdef SWEEP_TIMEOUT_EN
            if (expire) cap_q <= '0;
`endif
            if (state_q == S_COMPARE) begin
                if (win) begin
                    run_max_q <= cap_q;
                    run_ang_q <= cur_q;
                end
                if (state_d == S_SETTLE) cur_q <= nxt[7:0];
                // Publish the post-compare winner so the last point is included.
                if (state_d == S_DONE) begin
                    best_angle <= win ? cur_q : run_ang_q;
                    best_power <= win ? cap_q : run_max_q;
                end
            end
        end
    end

`ifdef SWEEP_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         terr_q <= 1'b0;
        else if (begin_sweep) terr_q <= 1'b0;
        else if (expire)      terr_q <= 1'b1;
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign wb_angle   = cur_q;
    assign wb_start   = (state_q == S_ISSUE);
    assign sweep_done = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/angle_sweep_ctrl.md
# angle_sweep_ctrl

Sequencer that steps the beam-steering angle across a configured range, issues one weight/power evaluation per angle, and keeps the angle with the highest returned power. It sits between the top-level start control and the weight/power datapath. At the end of each sweep it publishes the winning angle and power with a one-cycle done pulse, which drives the display block's done input.

## Interface
- ANG_MIN, default -90: first angle of the sweep, signed degrees.
- ANG_MAX, default 90: last allowed angle, signed degrees.
- ANG_STEP, default 5: angle increment, ≥1.
- PWR_W, default 32: power word width, unsigned.
- SETTLE, default 2: cycles wb_angle is held stable before wb_start, ≥1.
- TIMEOUT, default 4096: watchdog limit in WAIT, cycles (used only with SWEEP_TIMEOUT_EN).
- Parameter constraint: -128 ≤ ANG_MIN ≤ ANG_MAX ≤ 127.
- clk  in  1  single system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- continuous  in  1  when 1, a new sweep starts automatically after DONE.
- wb_angle  out  8 signed  angle under evaluation.
- wb_start  out  1  one-cycle pulse requesting an evaluation of wb_angle.
- wb_done  in  1  evaluation complete; wb_power is valid in the same cycle.
- wb_power  in  PWR_W  power result, unsigned.
- best_angle  out  8 signed  published winning angle of the last completed sweep.
- best_power  out  PWR_W  published winning power.
- sweep_done  out  1  one-cycle pulse when best_* are updated.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky watchdog flag; cleared at sweep start.

## Operation
- States: IDLE, SETTLE, ISSUE, WAIT, COMPARE, DONE.
- IDLE: if start=1, load cur=ANG_MIN, clear run_max and run_ang (to ANG_MIN), clear timeout_err, go to SETTLE. Otherwise stay in IDLE.
- SETTLE: wb_angle=cur. Stay for SETTLE cycles, then go to ISSUE.
- ISSUE: wb_start=1 for this cycle only. Go to WAIT.
- WAIT: on wb_done=1, capture wb_power and go to COMPARE.
- COMPARE: if captured power > run_max (strict), update run_max and run_ang=cur. Compute nxt=cur+ANG_STEP in 9-bit signed. If nxt > ANG_MAX, go to DONE; otherwise cur=nxt and go to SETTLE.
- DONE: best_angle=run_ang and best_power=run_max, registered on entry. sweep_done is high for the single DONE cycle. Next state is IDLE, or the same actions as IDLE-with-start if continuous=1.
- Ties resolve to the earliest (most negative) angle.
- If every point returns 0, best_angle=ANG_MIN and best_power=0.
- start while busy=1 is ignored. wb_done outside WAIT is ignored.
- Points per sweep: floor((ANG_MAX-ANG_MIN)/ANG_STEP)+1. With the defaults this is 37: -90..90.
- best_* hold their values across sweeps and change only in DONE, so the display stays stable mid-sweep.

## Timing
- Reset values: state=IDLE, wb_angle=0, wb_start=0, best_angle=0, best_power=0, sweep_done=0, busy=0, timeout_err=0.
- Reset asserted mid-sweep: everything returns to the reset values immediately. No partial result is published.
- Start sampled high at edge k: at k+1, state=SETTLE, wb_angle=ANG_MIN, busy=1.
- wb_start rises SETTLE cycles after SETTLE is entered.
- wb_done sampled at edge j: COMPARE occupies the cycle after j. SETTLE for the next point, or DONE, follows at j+2.
- Cycles per point = SETTLE + 1 + L + 1, where L = cycles from wb_start to wb_done, L ≥ 1.
- busy falls in the cycle after DONE when continuous=0.

## Configuration
- SWEEP_TIMEOUT_EN defined: WAIT has a counter. If wb_done has not arrived after TIMEOUT cycles:
  - set timeout_err=1;
  - treat the power as 0;
  - go to COMPARE.
  The sweep then continues normally.
- SWEEP_TIMEOUT_EN undefined: WAIT waits indefinitely, and timeout_err is tied to 0.

## Test plan
- Defaults, wb_done 3 cycles after each wb_start, power=100 except 500 at +30 → 37 wb_start pulses; sweep_done once; best_angle=30, best_power=500; busy low next cycle.
- Equal power 77 at -45 and +45, all others 10 → best_angle=-45, best_power=77 (tie goes to earliest).
- continuous=1, two sweeps with the peak at -90 then at +90 → best_angle=-90 after the first sweep_done, +90 after the second; no IDLE cycle between sweeps.
- reset_n pulsed low mid-sweep at wb_angle=0 → all outputs at reset values; a later start restarts at -90; best_* stay 0 until the next sweep_done.
- Spurious wb_done in SETTLE, and start pulses during WAIT → no state change, wb_start count stays 37.
- With SWEEP_TIMEOUT_EN and TIMEOUT=16, no wb_done at +10 → timeout_err=1 after 16 WAIT cycles; sweep completes; +10 scored as power 0.
